vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be one per line, given as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
REQ-002 Ports SHALL be one per line, given as name, direction, width, meaning:
- clk, in, 1, system clock (50 MHz).
- rst, in, 1, asynchronous active-high reset.
- pix_tick, out, 1, pixel-rate enable/VGA DAC clock (clk/2).
- x_pos, out, 10, current horizontal count, 0..H_TOTAL-1.
- y_pos, out, 10, current vertical count, 0..V_TOTAL-1.
- hsync, out, 1, horizontal sync, active low.
- vsync, out, 1, vertical sync, active low.
- blank_n, out, 1, high while (x_pos, y_pos) is in the visible area.
- sync_n, out, 1, DAC composite sync, constant 0.
- frame_start, out, 1, one-clk pulse when the counters wrap to (0,0).
- frame_cnt, out, 8, frame counter (see Configuration).
REQ-003 The block SHALL have one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-005 pix_tick SHALL be a register that toggles on every clk rising edge.
REQ-006 Counters SHALL advance only on a clk edge where pix_tick==1, i.e. once every 2 clk cycles.
REQ-007 On an advance, x_pos SHALL increment; at x_pos==H_TOTAL-1 it SHALL wrap to 0 and y_pos SHALL increment.
REQ-008 When x_pos==H_TOTAL-1 and y_pos==V_TOTAL-1, both counters SHALL wrap to 0 on the same advance.
REQ-009 hsync, vsync and blank_n SHALL be registered, computed from the next counter values and updated on the same edge as x_pos/y_pos, so they have zero skew relative to the counters.
REQ-010 hsync SHALL be 0 exactly when x_pos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751] by default).
REQ-011 vsync SHALL be 0 exactly when y_pos is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491] by default).
REQ-012 blank_n SHALL be 1 exactly when x_pos<H_ACTIVE and y_pos<V_ACTIVE.
REQ-013 frame_start SHALL be high for exactly one clk cycle, following the advance that loads (0,0); it SHALL be 0 at all other times.
REQ-014 A frame SHALL be H_TOTAL*V_TOTAL*2 clk cycles long (840000 by default); no other input affects sequencing.
REQ-015 sync_n SHALL be driven constant 0.

Reset
REQ-016 While rst is high, outputs SHALL be: pix_tick=0, x_pos=0, y_pos=0, hsync=1, vsync=1, blank_n=0, frame_start=0, frame_cnt=0.
REQ-017 rst asserted mid-line or mid-frame SHALL force the REQ-016 values immediately, without waiting for a clock edge.
REQ-018 After rst deasserts:
- The first clk edge SHALL set pix_tick=1.
- The second clk edge SHALL advance the counters to (1,0) with blank_n=1.
- blank_n SHALL be 0 at (0,0) for the first frame after reset only.
- frame_start SHALL NOT pulse on reset release.

Configuration
REQ-019 When macro VGA_SYNC_GEN_FRAME_CNT_EN is defined:
- frame_cnt SHALL increment by 1 in the same clk cycle that frame_start is high.
- frame_cnt SHALL wrap from 255 to 0.
REQ-020 When VGA_SYNC_GEN_FRAME_CNT_EN is undefined:
- frame_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.
- The port list SHALL be identical to the macro-defined build.

Verification
REQ-021 Release rst, then count clk edges -> pix_tick toggles every clk; x_pos reaches 1 at the 2nd edge and 639 at edge 1278; blank_n is 0 at x_pos=640.
REQ-022 Run one full line -> hsync is low for exactly 192 clk cycles starting at x_pos=656; x_pos wraps 799->0 and y_pos increments by 1.
REQ-023 Run one full frame -> vsync is low for exactly 2 lines (3200 clk) starting at y_pos=490; frame_start pulses once, 840000 clk after the previous pulse.
REQ-024 Assert rst asynchronously at x_pos=400, y_pos=300 -> all outputs reach their REQ-016 values before the next clk edge; timing restarts per REQ-018.
REQ-025 With VGA_SYNC_GEN_FRAME_CNT_EN defined, run 257 frames -> frame_cnt reads 1 after the 257th frame_start (wrapped 255->0). With the macro undefined -> frame_cnt stays 0.
REQ-026 Sample every pixel of one frame -> count of blank_n==1 equals 307200, and blank_n==1 never coincides with hsync==0 or vsync==0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, x/y counters and registered syncs.
// Define VGA_SYNC_GEN_FRAME_CNT_EN to enable the 8-bit frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_tick_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_wrap;

  // Syncs and blank are derived from the next counter values so they land
  // on the same edge as the counters they describe.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    frame_start_d = 1'b0;
    frame_wrap    = 1'b0;
    if (pix_tick_q) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d        = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
      hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
      vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
      blank_n_d     = (x_d < H_VIS_END) && (y_d < V_VIS_END);
      frame_start_d = frame_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tick_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= ~pix_tick_q;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the same edge that raises frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

  assign pix_tick    = pix_tick_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign sync_n      = 1'b0;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a shrunken 12x8 timing so whole
// frames (and 257 frames with VGA_SYNC_GEN_FRAME_CNT_EN) fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int HA  = 6;
  localparam int HFP = 2;
  localparam int HSW = 2;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // {pix_tick, x, y, hsync, vsync, blank_n, frame_start, sync_n, frame_cnt}
  typedef logic [33:0] obs_t;
  typedef struct {
    int   edges;
    obs_t exp;
  } vec_t;

  localparam obs_t RESET_OBS = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_tick;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       sync_n;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int edgeCount;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .x_pos(x_pos), .y_pos(y_pos),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Number of clk edges seen since reset was last released.
  always @(posedge clk or posedge rst) begin
    if (rst) edgeCount <= 0;
    else     edgeCount <= edgeCount + 1;
  end

  // Reference: every two clk edges is one pixel; position is the pixel index
  // modulo the frame, with syncs and blank decoded straight from x and y.
  function automatic obs_t modelAt(input int n);
    int p, pos, x, y;
    logic pt, hs, vs, bl, fs;
    logic [7:0] fc;
    p   = n / 2;
    pos = p % FT;
    x   = pos % HT;
    y   = pos / HT;
    pt  = (n % 2) == 1;
    bl  = (n >= 2) && (x < HA) && (y < VA);
    hs  = !((x >= HA + HFP) && (x < HA + HFP + HSW));
    vs  = !((y >= VA + VFP) && (y < VA + VFP + VSW));
    fs  = (n >= 2) && ((n % 2) == 0) && (pos == 0);
    fc  = FC_EN ? 8'((p / FT) % 256) : 8'd0;
    return {pt, 10'(x), 10'(y), hs, vs, bl, fs, 1'b0, fc};
  endfunction

  function automatic obs_t observed();
    return {pix_tick, x_pos, y_pos, hsync, vsync, blank_n, frame_start, sync_n, frame_cnt};
  endfunction

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t got;
    got = observed();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got pt=%b x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b sn=%b fc=%0d, expected pt=%b x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b sn=%b fc=%0d",
               name, $time, got[33], got[32:23], got[22:13], got[12], got[11], got[10], got[9], got[8], got[7:0],
               exp[33], exp[32:23], exp[22:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetHeld", RESET_OBS);
    rst = 1'b0;
  endtask

  // Free-run for a number of cycles, comparing every cycle with the model.
  task automatic applyStimulus(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput(name, modelAt(edgeCount));
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [7:0] fcOne;
    int hsLow, vsLow, blankCyc, overlap, pulses, waited, frames;
    fcOne = FC_EN ? 8'd1 : 8'd0;

    vecs[0]  = '{0,   {1'b0, 10'd0,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[1]  = '{1,   {1'b1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[2]  = '{2,   {1'b0, 10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
    vecs[3]  = '{11,  {1'b1, 10'd5,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
    vecs[4]  = '{12,  {1'b0, 10'd6,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[5]  = '{16,  {1'b0, 10'd8,  10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[6]  = '{20,  {1'b0, 10'd10, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[7]  = '{24,  {1'b0, 10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
    vecs[8]  = '{96,  {1'b0, 10'd0,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[9]  = '{120, {1'b0, 10'd0,  10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}};
    vecs[10] = '{192, {1'b0, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, fcOne}};
    vecs[11] = '{193, {1'b1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fcOne}};

    rst = 1'b1;
    resetDut();
    for (int i = 0; i < 12; i++) begin
      while (edgeCount < vecs[i].edges) @(negedge clk);
      checkOutput($sformatf("vec%0d_edge%0d", i, vecs[i].edges), vecs[i].exp);
    end

    // Measure one frame starting at a frame_start pulse.
    resetDut();
    waited = 0;
    while (!frame_start && waited < 2 * FT + 10) begin
      @(negedge clk);
      waited++;
    end
    checkValue("firstFrameStartSeen", int'(frame_start), 1);
    hsLow = 0; vsLow = 0; blankCyc = 0; overlap = 0; pulses = 0;
    for (int c = 0; c < 2 * FT; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("frameWalk", modelAt(edgeCount));
      if (!hsync && y_pos == 10'd0) hsLow++;
      if (!vsync) vsLow++;
      if (blank_n) blankCyc++;
      if (blank_n && (!hsync || !vsync)) overlap++;
      if (frame_start) pulses++;
    end
    checkValue("hsyncLowCyclesLine0", hsLow, 2 * HSW);
    checkValue("vsyncLowCycles", vsLow, 2 * HT * VSW);
    checkValue("visiblePixels", blankCyc / 2, HA * VA);
    checkValue("blankSyncOverlap", overlap, 0);
    checkValue("frameStartPulses", pulses, 1);
    @(negedge clk);
    checkValue("framePeriod", int'(frame_start), 1);

    // Random free-running stretches cut short by asynchronous resets.
    for (int it = 0; it < 6; it++) begin
      applyStimulus($urandom_range(30, 500), "randomRun");
      @(negedge clk);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      checkOutput("asyncReset", RESET_OBS);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      checkOutput("resetHold", RESET_OBS);
      rst = 1'b0;
      applyStimulus(4, "afterRelease");
    end

    // Frame counter run: 257 frames when enabled, a few otherwise.
    frames = FC_EN ? 257 : 3;
    resetDut();
    pulses = 0;
    waited = 0;
    while (pulses < frames && waited < frames * 2 * FT + 20) begin
      @(negedge clk);
      waited++;
      if (frame_start) pulses++;
    end
    checkValue("longRunPulses", pulses, frames);
    checkValue("longRunCycles", waited, frames * 2 * FT);
    checkValue("frameCntAfterRun", int'(frame_cnt), FC_EN ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
